window_ctrl_3x3: RTL and testbench
==================================

Name: window_ctrl_3x3

Overview:
- Downstream consumer of the three per-row reg_fifo instances: pops 24-bit row triplets and assembles 72-bit 3x3 windows.
- Presents windows to the processing stage over a valid/ready handshake.
- Tracks column and row position, pulses one_row_complete back to the fifos at row end, and flags end of frame.

Parameters:
- IMG_W, 32, image width in pixels; must be even and at least 4.
- IMG_H, 32, image height in output rows at stride 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins or restarts a frame.
- stride2en  in  1  stride-2 mode; sampled on start and held for the frame.
- fifo_count0/1/2  in  4  occupancy of row fifos 0, 1 and 2.
- fifo_data0/1/2  in  24  head-of-fifo pixel triplets, oldest pixel in bits [7:0].
- fifo_pop  out  1  common pop to all three fifos.
- one_row_complete  out  1  one-cycle pulse to the fifos at row end.
- window_data  out  72  {fifo_data2, fifo_data1, fifo_data0}, registered.
- window_valid  out  1  window_data holds a window.
- window_ready  in  1  consumer accepts the window.
- frame_done  out  1  one-cycle pulse after the last window of the frame is accepted.
- stall_cycles  out  32  back-pressure counter (see Optional Feature).

Behaviour:
- Reset: state IDLE; all outputs 0; column, row and stall counters 0.
- States are IDLE, RUN, ROW_END and DONE.
- IDLE to RUN on start. start in any state aborts the current frame: counters clear, window_valid drops, state goes to RUN, and stride2en is re-latched.
- WPR (windows per row) = IMG_W at stride 1, IMG_W/2 at stride 2.
- RPF (rows per frame) = IMG_H at stride 1, IMG_H/2 at stride 2.
- fifo_pop is combinational and equals RUN & all three counts >= 3 & (~window_valid | window_ready).
- Pop-to-valid latency is 1 cycle: on a pop, window_data loads the fifo heads and window_valid goes to 1 the next cycle.
- window_valid clears on acceptance (valid & ready) with no simultaneous pop.
- Simultaneous accept and pop: the output register reloads and window_valid stays 1, giving full throughput of 1 window per cycle.
- Output stability: while window_valid=1 and window_ready=0, window_data must not change.
- Each pop increments col (range 0..WPR-1). A pop with col == WPR-1 clears col and moves the state to ROW_END; no further pops occur in ROW_END.
- ROW_END waits until window_valid=0 or the window is accepted this cycle. In that cycle:
  - one_row_complete=1 and row increments.
  - If row == RPF-1, the state goes to DONE; otherwise it returns to RUN.
- DONE: frame_done=1 for one cycle, then IDLE. one_row_complete is not asserted again in DONE.
- Any fifo count < 3 in RUN is a stall with no pop; no timeout.
- Counters are sized $clog2(IMG_W) for col and $clog2(IMG_H) for row, and wrap only via the rules above.
- reset mid-frame has the same effect as power-on reset. start and reset in the same cycle: reset wins.

Optional Feature:
- Macro: WINDOW_CTRL_PERF_EN.
- Defined: stall_cycles increments every cycle in which window_valid & ~window_ready. It saturates at 32'hFFFFFFFF and clears on reset or start.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Decomposition:
- Shared package window_pkg holds:
  - state enum {IDLE, RUN, ROW_END, DONE};
  - constants PIX_W=8, ROW_TAP_W=24, WIN_W=72, FIFO_CNT_W=4, POP_THRESH=3.
- One natural sub-module: window_out_reg, the 72-bit valid/ready output register holding the load, hold and clear rules.
- The FSM and counters stay in the top level.

Test Plan:
- Reset, start with stride2en=0, IMG_W=4, IMG_H=2, counts=8, ready=1, fifo_data0/1/2 = 24'h030201/24'h131211/24'h232221 -> 8 windows, the first 72'h232221_131211_030201; one_row_complete pulses after windows 4 and 8; frame_done one cycle after the last acceptance.
- Hold ready=0 for 5 cycles after the first valid -> fifo_pop=0, window_data stable, and stall_cycles=5 when the macro is defined (0 when undefined).
- Stride 2, IMG_W=8, IMG_H=4 -> 4 windows per row, 2 row pulses, frame_done after 8 accepted windows.
- fifo_count1=2 while the others are 8 -> no pop; raise it to 3 -> pop next cycle, valid the cycle after.
- Assert start mid-row (col=2) -> window_valid=0 next cycle, col=0, row=0, then a normal frame.
- Assert reset during ROW_END -> all outputs 0 next cycle, and no one_row_complete or frame_done pulse.

Source files
------------

// File: rtl/window_pkg.sv
// Shared definitions for the 3x3 window controller.
//   win_state_t  : controller states (IDLE, RUN, ROW_END, DONE)
//   PIX_W        : bits per pixel
//   ROW_TAP_W    : bits per fifo head (three pixels, oldest in [7:0])
//   WIN_W        : bits per assembled 3x3 window
//   FIFO_CNT_W   : width of the row fifo occupancy counts
//   POP_THRESH   : minimum occupancy in every fifo before a pop
package window_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    ROW_END = 2'd2,
    DONE    = 2'd3
  } win_state_t;

  localparam int PIX_W      = 8;
  localparam int ROW_TAP_W  = 3 * PIX_W;
  localparam int WIN_W      = 3 * ROW_TAP_W;
  localparam int FIFO_CNT_W = 4;

  localparam logic [FIFO_CNT_W-1:0] POP_THRESH = 4'd3;

  // True when every row fifo holds enough triplets to build a window.
  function automatic logic counts_ready(input logic [FIFO_CNT_W-1:0] c0,
                                        input logic [FIFO_CNT_W-1:0] c1,
                                        input logic [FIFO_CNT_W-1:0] c2);
    return (c0 >= POP_THRESH) && (c1 >= POP_THRESH) && (c2 >= POP_THRESH);
  endfunction

endpackage

// File: rtl/window_out_reg.sv
// Valid/ready output register for assembled windows.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : drop the held window (frame abort)
//   load       : capture din and mark it valid
//   ready      : downstream accepts the held window
//   din        : window to capture, row taps packed {tap2, tap1, tap0}
//   data/valid : held window and its valid flag
// A load in the same cycle as an acceptance reloads the register and keeps
// valid high, so back-to-back windows flow at one per cycle.
module window_out_reg
  import window_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             ready,
  input  logic [WIN_W-1:0] din,
  output logic [WIN_W-1:0] data,
  output logic             valid
);

  logic                 valid_reg;
  logic                 valid_next;
  logic [ROW_TAP_W-1:0] tap_reg [3];

  always_comb begin
    valid_next = valid_reg;
    if (clear) begin
      valid_next = 1'b0;
    end else if (load) begin
      valid_next = 1'b1;
    end else if (valid_reg && ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  // One register per row tap; the taps only change on a load, which keeps
  // data stable while a window waits for ready.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tap
      always_ff @(posedge clk) begin
        if (reset) begin
          tap_reg[gi] <= '0;
        end else if (load) begin
          tap_reg[gi] <= din[gi*ROW_TAP_W +: ROW_TAP_W];
        end
      end
    end
  endgenerate

  assign data  = {tap_reg[2], tap_reg[1], tap_reg[0]};
  assign valid = valid_reg;

endmodule

// File: rtl/window_ctrl_3x3.sv
// 3x3 window controller: pops pixel triplets from three row fifos, presents
// 72-bit windows over valid/ready, tracks column/row position, pulses
// one_row_complete at each row end and frame_done after the last window.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   start                     : pulse, begins or restarts a frame
//   stride2en                 : stride-2 mode, latched on start
//   fifo_count0/1/2           : row fifo occupancies
//   fifo_data0/1/2            : row fifo heads, oldest pixel in [7:0]
//   fifo_pop                  : common pop to all three fifos
//   one_row_complete          : row-end pulse to the fifos
//   window_data/window_valid  : window output, window_ready accepts it
//   frame_done                : pulse after the last accepted window
//   stall_cycles              : back-pressure cycle count
// Build option: define WINDOW_CTRL_PERF_EN to build the stall counter;
// otherwise stall_cycles is constant zero.
module window_ctrl_3x3
  import window_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stride2en,
  input  logic [FIFO_CNT_W-1:0] fifo_count0,
  input  logic [FIFO_CNT_W-1:0] fifo_count1,
  input  logic [FIFO_CNT_W-1:0] fifo_count2,
  input  logic [ROW_TAP_W-1:0]  fifo_data0,
  input  logic [ROW_TAP_W-1:0]  fifo_data1,
  input  logic [ROW_TAP_W-1:0]  fifo_data2,
  output logic                  fifo_pop,
  output logic                  one_row_complete,
  output logic [WIN_W-1:0]      window_data,
  output logic                  window_valid,
  input  logic                  window_ready,
  output logic                  frame_done,
  output logic [31:0]           stall_cycles
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [COL_W-1:0] COL_LAST_S1 = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_LAST_S2 = COL_W'(IMG_W / 2 - 1);
  localparam logic [ROW_W-1:0] ROW_LAST_S1 = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_LAST_S2 = ROW_W'(IMG_H / 2 - 1);

  win_state_t       state_reg, state_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic             stride2_reg, stride2_next;

  logic             handoff;
  logic [COL_W-1:0] col_last;
  logic [ROW_W-1:0] row_last;

  // The output slot is free if empty or being emptied this cycle.
  assign handoff  = ~window_valid | window_ready;
  assign col_last = stride2_reg ? COL_LAST_S2 : COL_LAST_S1;
  assign row_last = stride2_reg ? ROW_LAST_S2 : ROW_LAST_S1;

  assign fifo_pop = (state_reg == RUN) && handoff &&
                    counts_ready(fifo_count0, fifo_count1, fifo_count2);

  always_comb begin
    state_next       = state_reg;
    col_next         = col_reg;
    row_next         = row_reg;
    stride2_next     = stride2_reg;
    one_row_complete = 1'b0;
    frame_done       = 1'b0;

    case (state_reg)
      IDLE: begin
      end
      RUN: begin
        if (fifo_pop) begin
          if (col_reg == col_last) begin
            col_next   = '0;
            state_next = ROW_END;
          end else begin
            col_next = col_reg + COL_W'(1);
          end
        end
      end
      ROW_END: begin
        // The row is finished only once its last window has left.
        if (handoff) begin
          one_row_complete = 1'b1;
          row_next         = row_reg + ROW_W'(1);
          state_next       = (row_reg == row_last) ? DONE : RUN;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // start aborts whatever is in flight and begins a fresh frame.
    if (start) begin
      state_next   = RUN;
      col_next     = '0;
      row_next     = '0;
      stride2_next = stride2en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      col_reg     <= '0;
      row_reg     <= '0;
      stride2_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      col_reg     <= col_next;
      row_reg     <= row_next;
      stride2_reg <= stride2_next;
    end
  end

  window_out_reg u_out (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .load  (fifo_pop),
    .ready (window_ready),
    .din   ({fifo_data2, fifo_data1, fifo_data0}),
    .data  (window_data),
    .valid (window_valid)
  );

`ifdef WINDOW_CTRL_PERF_EN
  logic [31:0] stall_reg;

  always_ff @(posedge clk) begin
    if (reset || start) begin
      stall_reg <= '0;
    end else if (window_valid && !window_ready && (stall_reg != 32'hFFFF_FFFF)) begin
      stall_reg <= stall_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_reg;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_window_ctrl_3x3.sv
// Directed bench for window_ctrl_3x3 (IMG_W=8, IMG_H=4) with a
// transaction-level reference model checked every cycle.
module tb_window_ctrl_3x3;

  localparam int W = 8;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stride2en = 1'b0;
  logic [3:0]  fifo_count0 = 4'd8;
  logic [3:0]  fifo_count1 = 4'd8;
  logic [3:0]  fifo_count2 = 4'd8;
  logic [23:0] fifo_data0 = 24'h030201;
  logic [23:0] fifo_data1 = 24'h131211;
  logic [23:0] fifo_data2 = 24'h232221;
  logic        fifo_pop;
  logic        one_row_complete;
  logic [71:0] window_data;
  logic        window_valid;
  logic        window_ready = 1'b1;
  logic        frame_done;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  window_ctrl_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .stride2en        (stride2en),
    .fifo_count0      (fifo_count0),
    .fifo_count1      (fifo_count1),
    .fifo_count2      (fifo_count2),
    .fifo_data0       (fifo_data0),
    .fifo_data1       (fifo_data1),
    .fifo_data2       (fifo_data2),
    .fifo_pop         (fifo_pop),
    .one_row_complete (one_row_complete),
    .window_data      (window_data),
    .window_valid     (window_valid),
    .window_ready     (window_ready),
    .frame_done       (frame_done),
    .stall_cycles     (stall_cycles)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame bookkeeping in window counts: pops are allowed while the current
  // row still has windows left; a row ends once all its windows are popped
  // and the last one has been handed over.
  bit          m_en = 0;
  bit          m_active = 0;
  bit          m_s2 = 0;
  int          m_popped = 0;
  int          m_rows = 0;
  bit          m_vld = 0;
  logic [71:0] m_data = '0;
  bit          m_fd_pend = 0;
  logic [31:0] m_stall = '0;
  bit          e_pop, e_orc, e_free, e_cnt_ok;
  int          wpr, rpf;

  // observation of DUT events
  int          cyc = 0;
  int          acc_cnt = 0, orc_cnt = 0, fd_cnt = 0;
  int          last_acc_cyc = 0, fd_cyc = 0;
  int          orc_at [8];
  logic [71:0] first_win = '0;

  always @(negedge clk) begin
    cyc++;
    wpr      = m_s2 ? W / 2 : W;
    rpf      = m_s2 ? H / 2 : H;
    e_cnt_ok = (fifo_count0 >= 3) && (fifo_count1 >= 3) && (fifo_count2 >= 3);
    e_free   = !m_vld || window_ready;
    e_pop    = m_active && (m_popped < (m_rows + 1) * wpr) && e_cnt_ok && e_free;
    e_orc    = m_active && (m_popped == (m_rows + 1) * wpr) && e_free;

    if (m_en) begin
      chk("mdl_pop", fifo_pop, e_pop);
      chk("mdl_row_complete", one_row_complete, e_orc);
      chk("mdl_frame_done", frame_done, m_fd_pend);
      chk("mdl_valid", window_valid, m_vld);
      if (m_vld) chk("mdl_data", window_data, m_data);
`ifdef WINDOW_CTRL_PERF_EN
      chk("mdl_stall", stall_cycles, m_stall);
`else
      chk("mdl_stall", stall_cycles, 0);
`endif
    end

    if (window_valid === 1'b1 && window_ready === 1'b1) begin
      if (acc_cnt == 0) first_win = window_data;
      acc_cnt++;
      last_acc_cyc = cyc;
    end
    if (one_row_complete === 1'b1) begin
      if (orc_cnt < 8) orc_at[orc_cnt] = acc_cnt;
      orc_cnt++;
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end

    if (reset) begin
      m_en = 1; m_active = 0; m_s2 = 0; m_popped = 0; m_rows = 0;
      m_vld = 0; m_data = '0; m_fd_pend = 0; m_stall = '0;
    end else if (start) begin
      m_active = 1; m_s2 = stride2en; m_popped = 0; m_rows = 0;
      m_vld = 0; m_fd_pend = 0; m_stall = '0;
      if (e_pop) m_data = {fifo_data2, fifo_data1, fifo_data0};
    end else begin
      if (m_vld && !window_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      m_fd_pend = 0;
      if (e_pop) begin
        m_data = {fifo_data2, fifo_data1, fifo_data0};
        m_vld = 1;
        m_popped++;
      end else if (m_vld && window_ready) begin
        m_vld = 0;
      end
      if (e_orc) begin
        m_rows++;
        if (m_rows == rpf) begin
          m_active  = 0;
          m_fd_pend = 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit         vary = 0;
  logic [7:0] vk = 8'h40;

  task automatic step();
    @(posedge clk);
    #1;
    if (vary) begin
      vk = vk + 8'd3;
      fifo_data0 = {vk + 8'd2, vk + 8'd1, vk};
      fifo_data1 = {vk + 8'd18, vk + 8'd17, vk + 8'd16};
      fifo_data2 = {vk + 8'd34, vk + 8'd33, vk + 8'd32};
    end
  endtask

  task automatic clear_obs();
    acc_cnt = 0; orc_cnt = 0; fd_cnt = 0; last_acc_cyc = 0; fd_cyc = 0;
    for (int i = 0; i < 8; i++) orc_at[i] = -1;
  endtask

  task automatic start_frame(input logic s2);
    stride2en = s2;
    start = 1'b1;
    step();
    start = 1'b0;
    clear_obs();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (fd_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (fd_cnt == 0) begin
      failures++;
      $display("FAIL %s_timeout actual=no_frame_done required=frame_done within %0d cycles", name, budget);
    end
  endtask

  task automatic pop_n(input int target);
    int pc = 0;
    int n = 0;
    while (pc < target && n < 50) begin
      if (fifo_pop) pc++;
      step();
      n++;
    end
    chk("pop_count_reached", 72'(pc), 72'(target));
  endtask

  logic [71:0] held;
  int          vwait;

  initial begin
    // ---- reset ----
    repeat (3) step();
    chk("rst_valid", window_valid, 0);
    chk("rst_data", window_data, 0);
    chk("rst_pop", fifo_pop, 0);
    chk("rst_row_complete", one_row_complete, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_stall", stall_cycles, 0);
    reset = 1'b0;
    step();
    chk("idle_pop", fifo_pop, 0);

    // ---- stride 1 full frame, constant data ----
    start_frame(1'b0);
    wait_done("s1", 200);
    $display("frame s1: windows=%0d rows=%0d done=%0d", acc_cnt, orc_cnt, fd_cnt);
    chk("s1_first_window", first_win, 72'h232221_131211_030201);
    chk("s1_windows", 72'(acc_cnt), 72'd32);
    chk("s1_row_pulses", 72'(orc_cnt), 72'd4);
    chk("s1_row0_after", 72'(orc_at[0]), 72'd8);
    chk("s1_row3_after", 72'(orc_at[3]), 72'd32);
    chk("s1_done_gap", 72'(fd_cyc - last_acc_cyc), 72'd1);
    chk("s1_frame_done_cnt", 72'(fd_cnt), 72'd1);

    // ---- back-pressure hold ----
    window_ready = 1'b0;
    start_frame(1'b0);
    vwait = 0;
    while (!window_valid && vwait < 20) begin
      step();
      vwait++;
    end
    chk("hold_valid_seen", window_valid, 1);
    held = window_data;
    for (int i = 0; i < 5; i++) begin
      chk("hold_pop", fifo_pop, 0);
      chk("hold_data", window_data, held);
`ifdef WINDOW_CTRL_PERF_EN
      chk("hold_stall", stall_cycles, 72'(i));
`else
      chk("hold_stall", stall_cycles, 0);
`endif
      step();
    end
`ifdef WINDOW_CTRL_PERF_EN
    chk("hold_stall_final", stall_cycles, 72'd5);
`else
    chk("hold_stall_final", stall_cycles, 72'd0);
`endif
    chk("hold_data_final", window_data, 72'h232221_131211_030201);
    window_ready = 1'b1;
    wait_done("hold", 200);
    $display("frame hold: windows=%0d rows=%0d stall=%0d", acc_cnt, orc_cnt, stall_cycles);
    chk("hold_windows", 72'(acc_cnt), 72'd32);

    // ---- stride 2, changing data ----
    vary = 1;
    start_frame(1'b1);
    wait_done("s2", 200);
    $display("frame s2: windows=%0d rows=%0d done=%0d", acc_cnt, orc_cnt, fd_cnt);
    chk("s2_windows", 72'(acc_cnt), 72'd8);
    chk("s2_row_pulses", 72'(orc_cnt), 72'd2);
    chk("s2_row0_after", 72'(orc_at[0]), 72'd4);
    chk("s2_row1_after", 72'(orc_at[1]), 72'd8);
    chk("s2_done_gap", 72'(fd_cyc - last_acc_cyc), 72'd1);

    // ---- fifo underflow stall ----
    vary = 0;
    fifo_count1 = 4'd2;
    start_frame(1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("low_cnt_pop", fifo_pop, 0);
      chk("low_cnt_valid", window_valid, 0);
      step();
    end
    fifo_count1 = 4'd3;
    #1;
    chk("cnt3_pop", fifo_pop, 1);
    step();
    chk("cnt3_valid", window_valid, 1);
    fifo_count1 = 4'd8;
    wait_done("cnt", 200);
    $display("frame cnt: windows=%0d rows=%0d", acc_cnt, orc_cnt);
    chk("cnt_windows", 72'(acc_cnt), 72'd32);

    // ---- restart mid-row ----
    vary = 1;
    start_frame(1'b0);
    pop_n(2);
    start = 1'b1;
    step();
    start = 1'b0;
    clear_obs();
    chk("restart_valid", window_valid, 0);
    wait_done("restart", 200);
    $display("frame restart: windows=%0d rows=%0d done=%0d", acc_cnt, orc_cnt, fd_cnt);
    chk("restart_windows", 72'(acc_cnt), 72'd32);
    chk("restart_row0_after", 72'(orc_at[0]), 72'd8);
    chk("restart_row_pulses", 72'(orc_cnt), 72'd4);

    // ---- reset during ROW_END ----
    vary = 0;
    start_frame(1'b1);
    pop_n(4);
    window_ready = 1'b0;
    #1;
    chk("rowend_no_pulse", one_row_complete, 0);
    step();
    chk("rowend_held_valid", window_valid, 1);
    chk("rowend_no_pop", fifo_pop, 0);
    reset = 1'b1;
    step();
    chk("midrst_valid", window_valid, 0);
    chk("midrst_data", window_data, 0);
    chk("midrst_pop", fifo_pop, 0);
    chk("midrst_row_complete", one_row_complete, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_stall", stall_cycles, 0);
    reset = 1'b0;
    window_ready = 1'b1;
    repeat (4) step();
    $display("reset during row end: rows=%0d done=%0d", orc_cnt, fd_cnt);
    chk("midrst_no_row_pulse", 72'(orc_cnt), 72'd0);
    chk("midrst_no_frame_done", 72'(fd_cnt), 72'd0);
    chk("midrst_idle_valid", window_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
